// File: rtl/pulse_train_gen.sv
// Programmable pulse train: period P+1 cycles, H high cycles, optional burst of B periods (0 = continuous).
// Define PULSE_TRAIN_PAUSE_EN to add a pause input that freezes the running train.
module pulse_train_gen #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BURST_W    = 8,
    parameter int unsigned DEF_PERIOD = 49999,
    parameter int unsigned DEF_HIGH   = 4999,
    parameter int unsigned DEF_BURST  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_load,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
`ifdef PULSE_TRAIN_PAUSE_EN
    input  logic               pause,
`endif
    output logic               pulse_out,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   high_reg;
    logic [BURST_W-1:0] burst_reg;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     count_inc;
    logic               entry_high;
    logic               paused;

`ifdef PULSE_TRAIN_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // One extra bit so the comparison stays correct when P is all ones.
    assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};

    // A start from IDLE sees a config loaded in the same cycle.
    assign entry_high = (state == IDLE && cfg_load) ? (cfg_high != '0) : (high_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            period_reg <= CNT_W'(DEF_PERIOD);
            high_reg   <= CNT_W'(DEF_HIGH);
            burst_reg  <= BURST_W'(DEF_BURST);
            count      <= '0;
            pulse_cnt  <= '0;
            pulse_out  <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    if (cfg_load) begin
                        period_reg <= cfg_period;
                        high_reg   <= cfg_high;
                        burst_reg  <= cfg_burst;
                    end
                    if (start && !stop) begin
                        state     <= RUN;
                        count     <= '0;
                        pulse_cnt <= BURST_W'(1);
                        tick      <= 1'b1;
                        pulse_out <= entry_high;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end else if (start) begin
                        count     <= '0;
                        pulse_cnt <= BURST_W'(1);
                        tick      <= 1'b1;
                        pulse_out <= entry_high;
                    end else if (paused) begin
                        state <= RUN;
                    end else if (count == period_reg) begin
                        if (burst_reg != '0 && pulse_cnt == burst_reg) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            pulse_out <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            count     <= '0;
                            pulse_cnt <= pulse_cnt + BURST_W'(1);
                            tick      <= 1'b1;
                            pulse_out <= entry_high;
                        end
                    end else begin
                        count     <= count_inc[CNT_W-1:0];
                        pulse_out <= (count_inc < {1'b0, high_reg});
                    end
                end
                DONE: begin
                    if (start && !stop) begin
                        state     <= RUN;
                        count     <= '0;
                        pulse_cnt <= BURST_W'(1);
                        tick      <= 1'b1;
                        pulse_out <= entry_high;
                        busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
